divisor_ctrl: RTL and testbench
===============================

// Module: divisor_ctrl
// PURPOSE
//   Run-time controller for the system clock divider. Counts a programmable
//   number of clk cycles and produces a 1-cycle tick enable plus a divided
//   square wave (clk_div_o). Accepts new divide ratios over a valid/ready
//   handshake and applies them only at a period boundary, so no runt pulse
//   appears. Sits between the 27 MHz clk domain logic and every block that
//   needs a slow enable.
// PARAMETERS
//   WIDTH        16     width of divide ratio and internal counter
//   DEFAULT_DIV  27000  ratio loaded at reset (27 MHz -> 1 kHz); must be >= 2
// PORTS
//   clk          in   1      system clock; all logic on rising edge
//   rst_n        in   1      reset, synchronous, active-low
//   en_i         in   1      1 = run divider, 0 = stop and clear counter
//   div_i        in   WIDTH  requested divide ratio
//   div_valid_i  in   1      div_i valid; transfer when valid & ready
//   div_ready_o  out  1      controller can accept a new ratio
//   tick_o       out  1      1-cycle pulse on last cycle of each period
//   clk_div_o    out  1      divided square wave
//   div_cur_o    out  WIDTH  ratio currently in effect
//   busy_o       out  1      1 when state != STOP
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=STOP, cnt=0, div_cur=DEFAULT_DIV,
//   div_pend=0; outputs: tick_o=0, clk_div_o=0, busy_o=0, div_ready_o=1,
//   div_cur_o=DEFAULT_DIV. Reset mid-period aborts period and drops pending
//   ratio.
// - Ratio clamp: any accepted div_i < 2 is stored as 2.
// - FSM states: STOP, RUN, PEND.
//   STOP: cnt held 0. Accepted ratio written directly to div_cur.
//         en_i=1 -> RUN.
//   RUN:  cnt increments; at cnt==div_cur-1 wraps to 0.
//         Accepted ratio -> latched into div_pend, go PEND.
//         en_i=0 -> STOP.
//   PEND: counts as RUN with old div_cur. At cnt==div_cur-1:
//         div_cur<=div_pend, cnt<=0, go RUN.
//         en_i=0 -> STOP, with div_cur<=div_pend (pending ratio never lost).
// - en_i=0 has priority over the terminal-count transition. A ratio accepted
//   in RUN in the same cycle en_i=0 goes to div_cur; state -> STOP.
// - div_ready_o = (state != PEND). It depends on state only, never on
//   div_valid_i.
// - tick_o = (state != STOP) && (cnt == div_cur-1).
//   clk_div_o = (state != STOP) && (cnt < div_cur>>1).
//   For odd ratio N: high floor(N/2) cycles, low ceil(N/2) cycles.
// - Latency: entering RUN at edge E puts cnt=0 in cycle E..E+1. The first
//   tick_o is asserted in cycle div_cur-1 after E, then once every div_cur
//   cycles.
// - New ratio takes effect on the first period starting after the current
//   period completes. The period in progress is never shortened or stretched.
// - cnt is WIDTH bits. div_cur <= 2^WIDTH-1, so no overflow.
// TESTING (clk period 37.04 ns; bench overrides DEFAULT_DIV=4)
// 1 Reset: rst_n=0 for 3 clk, then 1 ->
//   tick_o=0, clk_div_o=0, busy_o=0, div_ready_o=1, div_cur_o=4.
// 2 Free run: en_i=1, no writes ->
//   tick_o every 4 clk; clk_div_o 2 high / 2 low; busy_o=1.
// 3 Mid-period change: running div 4, write div_i=6 at cnt=1 ->
//   ready=0 until wrap; next tick still 3 clk later; then 6-cycle periods,
//   clk_div_o 3/3, div_cur_o=6.
// 4 Odd/clamp: write 5 ->
//   clk_div_o 2 high / 3 low. Write 0 and 1 -> div_cur_o=2, tick every 2 clk.
// 5 Stop in PEND: write 8 then en_i=0 before wrap ->
//   next cycle tick_o=0, clk_div_o=0, busy_o=0, div_ready_o=1, div_cur_o=8.
// 6 Reset mid-operation: rst_n=0 during PEND with div_pend=9 ->
//   div_cur_o=4, state STOP, pending ratio discarded.

Source files
------------

// File: rtl/divisor_ctrl.sv
// Programmable clock divider controller: tick enable plus divided square wave, with
// run-time ratio changes accepted over valid/ready and applied only at period boundaries.
`timescale 1ns/1ps

module divisor_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 27000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             tick_o,
    output logic             clk_div_o,
    output logic [WIDTH-1:0] div_cur_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        StStop,
        StRun,
        StPend
    } state_e;

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    state_e           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_div_pend;
    logic             r_tick;
    logic             r_clk_div;
    logic             r_busy;
    logic             r_ready;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_div_clamped;
    logic             w_last;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_tick_nxt;
    logic             w_clk_div_nxt;

    always_comb begin
        w_accept      = div_valid_i && (r_state != StPend);
        w_div_clamped = (div_i < MinDiv) ? MinDiv : div_i;
        w_last        = (r_cnt == (r_div_cur - One));
        w_cnt_inc     = w_last ? '0 : (r_cnt + One);

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_div_cur;
        w_pend_nxt  = r_div_pend;

        unique case (r_state)
            StStop: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_cur_nxt = w_div_clamped;
                end
                if (en_i) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                // Disable wins over everything; a ratio arriving alongside it goes live at once.
                if (!en_i) begin
                    w_state_nxt = StStop;
                    w_cnt_nxt   = '0;
                    if (w_accept) begin
                        w_cur_nxt = w_div_clamped;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_accept) begin
                        w_pend_nxt  = w_div_clamped;
                        w_state_nxt = StPend;
                    end
                end
            end
            StPend: begin
                if (!en_i) begin
                    w_state_nxt = StStop;
                    w_cnt_nxt   = '0;
                    w_cur_nxt   = r_div_pend;
                end else if (w_last) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = '0;
                    w_cur_nxt   = r_div_pend;
                end else begin
                    w_cnt_nxt = r_cnt + One;
                end
            end
            default: begin
                w_state_nxt = StStop;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered from next-state values so they line up with r_cnt/r_state.
        w_tick_nxt    = (w_state_nxt != StStop) && (w_cnt_nxt == (w_cur_nxt - One));
        w_clk_div_nxt = (w_state_nxt != StStop) && (w_cnt_nxt < (w_cur_nxt >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StStop;
            r_cnt      <= '0;
            r_div_cur  <= DefDiv;
            r_div_pend <= '0;
            r_tick     <= 1'b0;
            r_clk_div  <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_cur_nxt;
            r_div_pend <= w_pend_nxt;
            r_tick     <= w_tick_nxt;
            r_clk_div  <= w_clk_div_nxt;
            r_busy     <= (w_state_nxt != StStop);
            r_ready    <= (w_state_nxt != StPend);
        end
    end

    assign div_ready_o = r_ready;
    assign tick_o      = r_tick;
    assign clk_div_o   = r_clk_div;
    assign div_cur_o   = r_div_cur;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_divisor_ctrl.sv
// Scoreboard bench for divisor_ctrl: driver updates a period/position model and queues the
// expected outputs; a monitor pops and compares one entry after every clock edge.
`timescale 1ns/1ps

module tb_divisor_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         en_i;
    logic [W-1:0] div_i;
    logic         div_valid_i;
    logic         div_ready_o;
    logic         tick_o;
    logic         clk_div_o;
    logic [W-1:0] div_cur_o;
    logic         busy_o;

    divisor_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .tick_o      (tick_o),
        .clk_div_o   (clk_div_o),
        .div_cur_o   (div_cur_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #18.52 clk = ~clk;

    typedef struct {
        logic tick;
        logic clkd;
        logic busy;
        logic ready;
        int   cur;
    } exp_t;

    exp_t exp_q[$];
    int   n_err = 0;
    int   n_chk = 0;

    // Model: running flag, position inside the current period, ratio in use, waiting ratio.
    bit m_run = 0;
    int m_pos = 0;
    int m_cur = 4;
    int m_pend[$];

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs (called at negedge) and queue the outputs after the next edge.
    task automatic step(input bit rst, input bit en, input bit vld, input int dv);
        bit   acc;
        int   v;
        exp_t e;
        rst_n       = rst;
        en_i        = en;
        div_valid_i = vld;
        div_i       = W'(dv);
        acc = vld && (m_pend.size() == 0);
        v   = (dv < 2) ? 2 : dv;
        if (!rst) begin
            m_run = 0;
            m_pos = 0;
            m_cur = 4;
            m_pend.delete();
        end else if (!m_run) begin
            if (acc) m_cur = v;
            if (en) m_run = 1;
            m_pos = 0;
        end else if (!en) begin
            m_run = 0;
            m_pos = 0;
            if (m_pend.size() != 0) m_cur = m_pend.pop_front();
            else if (acc) m_cur = v;
        end else begin
            if (m_pos == m_cur - 1) begin
                m_pos = 0;
                if (m_pend.size() != 0) m_cur = m_pend.pop_front();
            end else begin
                m_pos++;
            end
            if (acc) m_pend.push_back(v);
        end
        e.tick  = m_run && (m_pos == m_cur - 1);
        e.clkd  = m_run && (m_pos < m_cur / 2);
        e.busy  = m_run;
        e.ready = (m_pend.size() == 0);
        e.cur   = m_cur;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0);
    endtask

    // Wait (bounded) until the model can accept, then offer one ratio.
    task automatic write(input int dv);
        int k = 0;
        while (m_pend.size() != 0 && k < 100) begin
            step(1, 1, 0, 0);
            k++;
        end
        step(1, 1, 1, dv);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tick_o", int'(tick_o), int'(e.tick));
                chk("clk_div_o", int'(clk_div_o), int'(e.clkd));
                chk("busy_o", int'(busy_o), int'(e.busy));
                chk("div_ready_o", int'(div_ready_o), int'(e.ready));
                chk("div_cur_o", int'(div_cur_o), e.cur);
            end
        end
    end

    // Driver
    initial begin
        int k;
        rst_n = 1'b0; en_i = 1'b0; div_valid_i = 1'b0; div_i = '0;
        @(negedge clk);
        // Reset and idle
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        // Free run at the default ratio
        run(13);
        // Mid-period change to 6 when the counter sits at 1
        k = 0;
        while (m_pos != 1 && k < 20) begin
            step(1, 1, 0, 0);
            k++;
        end
        step(1, 1, 1, 6);
        run(20);
        // Odd ratio and clamping of 0 and 1
        write(5);
        run(16);
        write(0);
        run(10);
        write(1);
        run(10);
        // Stop while a ratio of 8 is pending
        write(8);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        run(20);
        // Reset while a ratio of 9 is pending
        write(9);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        run(10);
        // Random traffic, ratio changes aimed at arbitrary phases
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) != 0), ($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 5) == 0), int'($urandom_range(0, 11)));
        end
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
